// File: rtl/ddr4_pkg.sv
// Shared types, address field positions and default DDR4 timing for the
// closed-page command scheduler.
package ddr4_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        OP_RD      = 2'd0,
        OP_WR      = 2'd1,
        OP_IFETCH  = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    localparam int ADDR_W = 33;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
    } req_t;

    localparam int ROW_MSB  = 32;
    localparam int ROW_LSB  = 18;
    localparam int HCOL_MSB = 17;
    localparam int HCOL_LSB = 10;
    localparam int BANK_MSB = 9;
    localparam int BANK_LSB = 8;
    localparam int BG_MSB   = 7;
    localparam int BG_LSB   = 6;
    localparam int LCOL_MSB = 5;
    localparam int LCOL_LSB = 3;

    localparam int DEPTH_DEF  = 16;
    localparam int TRCD_DEF   = 16;
    localparam int TRP_DEF    = 16;
    localparam int TRAS_DEF   = 39;
    localparam int TRTP_DEF   = 9;
    localparam int TCWL_DEF   = 12;
    localparam int TBURST_DEF = 4;
    localparam int TWR_DEF    = 18;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr4_req_fifo.sv
// Synchronous request FIFO; the head entry stays stable until popped.
module ddr4_req_fifo
    import ddr4_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  req_t                   wdata_i,
    input  logic                   pop_i,
    output req_t                   head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    req_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ddr4_cmd_scheduler.sv
// In-order closed-page scheduler: ACT -> RD/WR -> PRE per queued request.
// state    | meaning
// IDLE     | queue empty, no bank open
// ACT      | issue ACT for head (appears on cmd_* next cycle)
// WAIT_RCD | ACT-to-CAS spacing
// CAS      | issue RD or WR for head
// WAIT_PRE | hold bank open until tRAS / tRTP / write recovery met
// PRE      | issue PRE and report head as retired
// WAIT_RP  | precharge recovery before the next ACT
module ddr4_cmd_scheduler
    import ddr4_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TRCD   = TRCD_DEF,
    parameter int TRP    = TRP_DEF,
    parameter int TRAS   = TRAS_DEF,
    parameter int TRTP   = TRTP_DEF,
    parameter int TCWL   = TCWL_DEF,
    parameter int TBURST = TBURST_DEF,
    parameter int TWR    = TWR_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [32:0]            req_addr,
    output logic                   cmd_valid,
    output logic [2:0]             cmd_type,
    output logic [1:0]             cmd_bg,
    output logic [1:0]             cmd_bank,
    output logic [14:0]            cmd_row,
    output logic [10:0]            cmd_col,
    output logic                   done_valid,
    output logic [1:0]             done_op,
    output logic [32:0]            done_addr,
    output logic                   illegal_op,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int P_RD  = max2(TRAS, TRCD + TRTP);
    localparam int P_WR  = max2(TRAS, TRCD + TCWL + TBURST + TWR);
    localparam int T_MAX = max2(max2(P_RD, P_WR), TRP);
    localparam int TMR_W = $clog2(T_MAX) + 1;

    // A wait state loaded with N lasts N+1 cycles, and the command register
    // adds one more, hence the -2 on every spacing.
    localparam logic [TMR_W-1:0] LD_RCD    = TMR_W'(TRCD - 2);
    localparam logic [TMR_W-1:0] LD_PRE_RD = TMR_W'(P_RD - TRCD - 2);
    localparam logic [TMR_W-1:0] LD_PRE_WR = TMR_W'(P_WR - TRCD - 2);
    localparam logic [TMR_W-1:0] LD_RP     = TMR_W'(TRP - 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ACT, ST_WAIT_RCD, ST_CAS, ST_WAIT_PRE, ST_PRE, ST_WAIT_RP
    } state_e;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              cmd_valid_q, cmd_valid_d;
    cmd_e              cmd_type_q, cmd_type_d;
    logic [1:0]        cmd_bg_q, cmd_bg_d, cmd_bank_q, cmd_bank_d;
    logic [14:0]       cmd_row_q, cmd_row_d;
    logic [10:0]       cmd_col_q, cmd_col_d;
    logic              done_valid_q, done_valid_d;
    logic [1:0]        done_op_q, done_op_d;
    logic [32:0]       done_addr_q, done_addr_d;
    logic              illegal_q;

    logic              q_push, q_full, q_empty;
    req_t              q_wdata, head;
    logic [CW-1:0]     q_cnt, pending;

    assign q_push        = req_valid && !q_full;
    assign q_wdata.op    = op_e'(req_op);
    assign q_wdata.addr  = req_addr;
    // The entry reported by done_valid is popped at the end of that cycle.
    assign pending       = q_cnt - CW'(done_valid_q);

    ddr4_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (q_push),
        .wdata_i (q_wdata),
        .pop_i   (done_valid_q),
        .head_o  (head),
        .count_o (q_cnt),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        cmd_valid_d  = 1'b0;
        cmd_type_d   = CMD_NOP;
        cmd_bg_d     = '0;
        cmd_bank_d   = '0;
        cmd_row_d    = '0;
        cmd_col_d    = '0;
        done_valid_d = 1'b0;
        done_op_d    = '0;
        done_addr_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) state_d = ST_ACT;
            end
            ST_ACT: begin
                cmd_valid_d = 1'b1;
                cmd_type_d  = CMD_ACT;
                cmd_bg_d    = head.addr[BG_MSB:BG_LSB];
                cmd_bank_d  = head.addr[BANK_MSB:BANK_LSB];
                cmd_row_d   = head.addr[ROW_MSB:ROW_LSB];
                state_d     = ST_WAIT_RCD;
                tmr_d       = LD_RCD;
            end
            ST_WAIT_RCD: begin
                if (tmr_q == '0) state_d = ST_CAS;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            ST_CAS: begin
                cmd_valid_d = 1'b1;
                cmd_type_d  = (head.op == OP_WR) ? CMD_WR : CMD_RD;
                cmd_bg_d    = head.addr[BG_MSB:BG_LSB];
                cmd_bank_d  = head.addr[BANK_MSB:BANK_LSB];
                cmd_col_d   = {head.addr[HCOL_MSB:HCOL_LSB], head.addr[LCOL_MSB:LCOL_LSB]};
                state_d     = ST_WAIT_PRE;
                tmr_d       = (head.op == OP_WR) ? LD_PRE_WR : LD_PRE_RD;
            end
            ST_WAIT_PRE: begin
                if (tmr_q == '0) state_d = ST_PRE;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            ST_PRE: begin
                cmd_valid_d  = 1'b1;
                cmd_type_d   = CMD_PRE;
                cmd_bg_d     = head.addr[BG_MSB:BG_LSB];
                cmd_bank_d   = head.addr[BANK_MSB:BANK_LSB];
                done_valid_d = 1'b1;
                done_op_d    = head.op;
                done_addr_d  = head.addr;
                state_d      = ST_WAIT_RP;
                tmr_d        = LD_RP;
            end
            ST_WAIT_RP: begin
                if (tmr_q == '0) state_d = (pending != '0) ? ST_ACT : ST_IDLE;
                else             tmr_d   = tmr_q - TMR_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_type_q   <= CMD_NOP;
            cmd_bg_q     <= '0;
            cmd_bank_q   <= '0;
            cmd_row_q    <= '0;
            cmd_col_q    <= '0;
            done_valid_q <= 1'b0;
            done_op_q    <= '0;
            done_addr_q  <= '0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_type_q   <= cmd_type_d;
            cmd_bg_q     <= cmd_bg_d;
            cmd_bank_q   <= cmd_bank_d;
            cmd_row_q    <= cmd_row_d;
            cmd_col_q    <= cmd_col_d;
            done_valid_q <= done_valid_d;
            done_op_q    <= done_op_d;
            done_addr_q  <= done_addr_d;
            illegal_q    <= q_push && (req_op == 2'd3);
        end
    end

    assign req_ready  = !q_full;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_type   = cmd_type_q;
    assign cmd_bg     = cmd_bg_q;
    assign cmd_bank   = cmd_bank_q;
    assign cmd_row    = cmd_row_q;
    assign cmd_col    = cmd_col_q;
    assign done_valid = done_valid_q;
    assign done_op    = done_op_q;
    assign done_addr  = done_addr_q;
    assign illegal_op = illegal_q;
    assign q_count    = q_cnt;

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Directed bench for ddr4_cmd_scheduler: command latencies, spacing,
// back-pressure, retirement order, illegal op and asynchronous reset.
module tb_ddr4_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [32:0] req_addr = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bg, cmd_bank;
    logic [14:0] cmd_row;
    logic [10:0] cmd_col;
    logic        done_valid;
    logic [1:0]  done_op;
    logic [32:0] done_addr;
    logic        illegal_op;
    logic [4:0]  q_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int e0, t_act, t_cas, t_pre, t_act2, extra, dones;
    int idx, first_done, acc17, n_done, guard;
    logic full_seen, will;
    logic [32:0] fa [17];

    ddr4_cmd_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .cmd_bg     (cmd_bg),
        .cmd_bank   (cmd_bank),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .done_valid (done_valid),
        .done_op    (done_op),
        .done_addr  (done_addr),
        .illegal_op (illegal_op),
        .q_count    (q_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push1(input logic [1:0] op, input logic [32:0] addr);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
    endtask

    task automatic next_cmd(input int budget, output int at);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!cmd_valid && n < budget);
        at = cyc;
        check("cmd_within_budget", cmd_valid, 1'b1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held for 3 cycles
        #1 rst_n = 1'b0;
        steps(3);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_q_count", q_count, 5'd0);
        rst_n = 1'b1;
        step();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_cmd_type", cmd_type, 3'd0);
        check("rst_cmd_fields", {cmd_bg, cmd_bank, cmd_row, cmd_col}, 30'd0);
        check("rst_done", {done_valid, done_op, done_addr, illegal_op}, 37'd0);

        // single read
        push1(2'd0, 33'h0_0004_05C8);
        e0 = cyc;
        check("rd_q_count", q_count, 5'd1);
        check("rd_no_illegal", illegal_op, 1'b0);
        next_cmd(10, t_act);
        check("rd_act_lat", t_act - e0, 2);
        check("rd_act_type", cmd_type, 3'd1);
        check("rd_act_row", cmd_row, 15'd1);
        check("rd_act_bg", cmd_bg, 2'd3);
        check("rd_act_bank", cmd_bank, 2'd1);
        next_cmd(40, t_cas);
        check("rd_cas_lat", t_cas - t_act, 16);
        check("rd_cas_type", cmd_type, 3'd2);
        check("rd_cas_col", cmd_col, 11'h009);
        next_cmd(60, t_pre);
        check("rd_pre_lat", t_pre - t_act, 39);
        check("rd_pre_type", cmd_type, 3'd4);
        check("rd_done_valid", done_valid, 1'b1);
        check("rd_done_op", done_op, 2'd0);
        check("rd_done_addr", done_addr, 33'h0_0004_05C8);
        check("rd_q_before_pop", q_count, 5'd1);
        step();
        check("rd_q_empty", q_count, 5'd0);
        check("rd_done_pulse", done_valid, 1'b0);
        check("rd_cmd_nop", {cmd_valid, cmd_type}, 4'd0);
        steps(20);

        // single write, followed by silence
        push1(2'd1, 33'h1_2345_6789);
        e0 = cyc;
        next_cmd(10, t_act);
        check("wr_act_lat", t_act - e0, 2);
        check("wr_act_row", cmd_row, 15'h48D1);
        next_cmd(40, t_cas);
        check("wr_cas_lat", t_cas - t_act, 16);
        check("wr_cas_type", cmd_type, 3'd3);
        check("wr_cas_col", cmd_col, 11'h2C9);
        check("wr_cas_bgbank", {cmd_bg, cmd_bank}, 4'b1011);
        next_cmd(80, t_pre);
        check("wr_pre_lat", t_pre - t_act, 50);
        check("wr_done_op", done_op, 2'd1);
        check("wr_done_addr", done_addr, 33'h1_2345_6789);
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (cmd_valid) extra++;
        end
        check("wr_no_second_act", extra, 0);

        // back-to-back reads
        push1(2'd0, 33'h0_1000_0040);
        push1(2'd0, 33'h1_FFFF_FFFF);
        next_cmd(10, t_act);
        next_cmd(40, t_cas);
        next_cmd(60, t_pre);
        check("rr_done1", done_addr, 33'h0_1000_0040);
        next_cmd(40, t_act2);
        check("rr_act_spacing", t_act2 - t_act, 55);
        check("rr_act2_row", cmd_row, 15'h7FFF);
        next_cmd(40, t_cas);
        next_cmd(60, t_pre);
        check("rr_done2", done_addr, 33'h1_FFFF_FFFF);
        steps(20);

        // write then read
        push1(2'd1, 33'h0_0ABC_0300);
        push1(2'd0, 33'h0_0123_4567);
        next_cmd(10, t_act);
        next_cmd(40, t_cas);
        check("wrrd_cas1_type", cmd_type, 3'd3);
        next_cmd(80, t_pre);
        check("wrrd_done1", done_addr, 33'h0_0ABC_0300);
        next_cmd(40, t_act2);
        check("wrrd_act_spacing", t_act2 - t_act, 66);
        next_cmd(40, t_cas);
        check("wrrd_cas2_type", cmd_type, 3'd2);
        next_cmd(60, t_pre);
        check("wrrd_done2", done_addr, 33'h0_0123_4567);
        steps(20);

        // full queue: 17 requests with req_valid held
        for (int i = 0; i < 17; i++) fa[i] = {15'(i + 100), 18'(i * 65)};
        idx = 0; first_done = -1; acc17 = -1; n_done = 0; guard = 0; full_seen = 1'b0;
        req_valid = 1'b1; req_op = 2'd0; req_addr = fa[0];
        while (n_done < 17 && guard < 1500) begin
            will = req_valid && req_ready;
            if (q_count == 5'd16 && !full_seen) begin
                full_seen = 1'b1;
                check("full_ready_low", req_ready, 1'b0);
            end
            step();
            guard++;
            if (will) begin
                if (idx == 16) acc17 = cyc;
                idx++;
                if (idx < 17) req_addr = fa[idx];
                else          req_valid = 1'b0;
            end
            if (done_valid) begin
                check($sformatf("full_order_%0d", n_done), done_addr, fa[n_done]);
                if (first_done < 0) first_done = cyc;
                n_done++;
            end
        end
        req_valid = 1'b0;
        check("full_seen", full_seen, 1'b1);
        check("full_all_retired", n_done, 17);
        check("full_17th_accept", acc17 - first_done, 2);
        steps(20);

        // illegal op, then reset while the bank is open
        push1(2'd3, 33'h0_0008_0000);
        e0 = cyc;
        check("ill_pulse", illegal_op, 1'b1);
        step();
        check("ill_pulse_end", illegal_op, 1'b0);
        next_cmd(10, t_act);
        check("ill_act_lat", t_act - e0, 2);
        next_cmd(40, t_cas);
        check("ill_cas_type", cmd_type, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cmd_valid", cmd_valid, 1'b0);
        check("arst_cmd_type", cmd_type, 3'd0);
        check("arst_q_count", q_count, 5'd0);
        steps(2);
        rst_n = 1'b1;
        extra = 0; dones = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (cmd_valid) extra++;
            if (done_valid) dones++;
        end
        check("arst_no_pre", extra, 0);
        check("arst_no_done", dones, 0);
        check("arst_q_still_empty", q_count, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
